// File: rtl/abpm_pkt_pkg.sv
// Shared definitions for the ABPM slow-FIFO packet stream.
// The writer-side packer and the reader both use these definitions.
package abpm_pkt_pkg;

  localparam logic [31:0] PID       = 32'h4142504D;
  localparam int          PKT_WORDS = 16;

  // Word positions inside one packet
  localparam int W_PID   = 0;
  localparam int W_EVT   = 1;
  localparam int W_XY    = 2;
  localparam int W_S     = 3;
  localparam int W_PA    = 4;
  localparam int W_PB    = 5;
  localparam int W_PC    = 6;
  localparam int W_PD    = 7;
  localparam int W_MAXAB = 8;
  localparam int W_MAXCD = 9;
  localparam int W_XYCAL = 10;
  localparam int W_PAD   = 11;
  localparam int W_CALPA = 12;
  localparam int W_CALPB = 13;
  localparam int W_DRA   = 14;
  localparam int W_DRB   = 15;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HUNT   = 2'd1,
    S_BODY   = 2'd2,
    S_COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/slow_pkt_reader_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: step by one unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/slow_pkt_reader.sv
// Consumer of the ABPM slow-FIFO packet stream. Pulls one 16-word packet per
// event, resynchronises on the PID word after framing loss, checks event
// continuity and pad words, and holds the last good packet for the register map.
module slow_pkt_reader #(
  parameter int          SFIFO_WIDTH = 32,
  parameter int          DATA_WIDTH  = 16,
  parameter int          PKT_WORDS   = 16,
  parameter int          CNT_WIDTH   = 6,
  parameter logic [31:0] PID         = 32'h4142504D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [SFIFO_WIDTH-1:0] fifo_dout,
  input  logic [CNT_WIDTH-1:0]   fifo_rd_count,
  output logic                   fifo_rd,
  output logic                   pkt_valid,
  output logic [DATA_WIDTH-1:0]  evt_cnt,
  output logic [DATA_WIDTH-1:0]  status,
  output logic [DATA_WIDTH-1:0]  x_pos,
  output logic [DATA_WIDTH-1:0]  y_pos,
  output logic [DATA_WIDTH-1:0]  s_sum,
  output logic [SFIFO_WIDTH-1:0] power_a,
  output logic [SFIFO_WIDTH-1:0] power_b,
  output logic [SFIFO_WIDTH-1:0] power_c,
  output logic [SFIFO_WIDTH-1:0] power_d,
  input  logic [3:0]             word_sel,
  output logic [SFIFO_WIDTH-1:0] word_out,
  output logic [15:0]            sync_err_cnt,
  output logic [15:0]            evt_gap_cnt,
  output logic                   pad_err
);

  import abpm_pkt_pkg::*;

  localparam int                   IDX_W    = $clog2(PKT_WORDS);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(PKT_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(PKT_WORDS);

  state_e                 state_q, state_d;
  logic                   rd_s;
  logic                   rd_pend_q;
  logic [IDX_W-1:0]       rd_left_q, rd_left_d;
  logic [IDX_W-1:0]       rx_idx_q, rx_idx_d;
  logic                   burst_q, burst_d;
  logic                   hunt_err_q, hunt_err_d;
  logic [1:0]             guard_q, guard_d;
  logic                   pid_hit_s, cap_s, commit_s, sync_inc_s, gap_s, pad_s;
  logic [DATA_WIDTH-1:0]  evt_next_s;

  logic [SFIFO_WIDTH-1:0] buf_q [PKT_WORDS];
  logic [SFIFO_WIDTH-1:0] pkt_s [PKT_WORDS];
  logic [SFIFO_WIDTH-1:0] raw_q [PKT_WORDS];

  logic                   pkt_valid_q;
  logic [DATA_WIDTH-1:0]  evt_cnt_q, status_q, x_pos_q, y_pos_q, s_sum_q;
  logic [SFIFO_WIDTH-1:0] power_a_q, power_b_q, power_c_q, power_d_q;
  logic [SFIFO_WIDTH-1:0] word_out_q;
  logic                   pad_err_q;
  logic                   seen_q;

  // Read sequencing: start, PID hunt, 15-word burst, commit and guard
  always_comb begin
    state_d    = state_q;
    rd_s       = 1'b0;
    rd_left_d  = rd_left_q;
    rx_idx_d   = rx_idx_q;
    burst_d    = burst_q;
    hunt_err_d = hunt_err_q;
    guard_d    = guard_q;
    pid_hit_s  = 1'b0;
    cap_s      = 1'b0;
    commit_s   = 1'b0;
    sync_inc_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        hunt_err_d = 1'b0;
        if (guard_q != 2'd0) begin
          guard_d = guard_q - 2'd1;
        end else if (enable && (fifo_rd_count >= CNT_FULL)) begin
          rd_s    = 1'b1;
          state_d = S_HUNT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HUNT: begin
        // Only one read in flight here, so junk drains at one word per two cycles
        if (rd_pend_q) begin
          if (fifo_dout == PID) begin
            pid_hit_s  = 1'b1;
            state_d    = S_BODY;
            rd_left_d  = LAST_IDX;
            rx_idx_d   = {{(IDX_W-1){1'b0}}, 1'b1};
            burst_d    = 1'b0;
            hunt_err_d = 1'b0;
          end else begin
            sync_inc_s = ~hunt_err_q;
            hunt_err_d = 1'b1;
          end
        end else if (fifo_rd_count != {CNT_WIDTH{1'b0}}) begin
          rd_s = 1'b1;
        end else begin
          rd_s = 1'b0;
        end
      end
      S_BODY: begin
        if (rd_pend_q) begin
          cap_s = 1'b1;
          if (rx_idx_q == LAST_IDX) begin
            commit_s = 1'b1;
            state_d  = S_COMMIT;
          end else begin
            rx_idx_d = rx_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          cap_s = 1'b0;
        end
        // Full-packet count is required once; after that the burst runs back to back
        if ((burst_q || (fifo_rd_count >= CNT_FULL)) &&
            (rd_left_q != {IDX_W{1'b0}}) && (fifo_rd_count != {CNT_WIDTH{1'b0}})) begin
          rd_s      = 1'b1;
          burst_d   = 1'b1;
          rd_left_d = rd_left_q - {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
          rd_s = 1'b0;
        end
      end
      S_COMMIT: begin
        guard_d = 2'd2;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state registers; reset also drops any read still in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_pend_q  <= 1'b0;
      rd_left_q  <= {IDX_W{1'b0}};
      rx_idx_q   <= {IDX_W{1'b0}};
      burst_q    <= 1'b0;
      hunt_err_q <= 1'b0;
      guard_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_s;
      rd_left_q  <= rd_left_d;
      rx_idx_q   <= rx_idx_d;
      burst_q    <= burst_d;
      hunt_err_q <= hunt_err_d;
      guard_q    <= guard_d;
    end
  end

  // Assembly buffer for the packet in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PKT_WORDS; i++) begin
        buf_q[i] <= {SFIFO_WIDTH{1'b0}};
      end
    end else begin
      if (pid_hit_s) begin
        buf_q[W_PID] <= fifo_dout;
      end
      if (cap_s) begin
        buf_q[rx_idx_q] <= fifo_dout;
      end
    end
  end

  // Complete packet view at commit: last word comes straight from the FIFO
  always_comb begin
    for (int i = 0; i < PKT_WORDS; i++) begin
      pkt_s[i] = buf_q[i];
    end
    pkt_s[PKT_WORDS-1] = fifo_dout;
  end

  // Continuity and pad checks on the packet being committed
  always_comb begin
    evt_next_s = evt_cnt_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    gap_s      = commit_s && seen_q && (pkt_s[W_EVT][DATA_WIDTH-1:0] != evt_next_s);
    pad_s      = (pkt_s[W_S][DATA_WIDTH-1:0] != {DATA_WIDTH{1'b0}}) ||
                 (pkt_s[W_PAD] != {SFIFO_WIDTH{1'b0}});
  end

  // Published fields, raw copy and flags; only a full packet ever updates them
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_valid_q <= 1'b0;
      evt_cnt_q   <= {DATA_WIDTH{1'b0}};
      status_q    <= {DATA_WIDTH{1'b0}};
      x_pos_q     <= {DATA_WIDTH{1'b0}};
      y_pos_q     <= {DATA_WIDTH{1'b0}};
      s_sum_q     <= {DATA_WIDTH{1'b0}};
      power_a_q   <= {SFIFO_WIDTH{1'b0}};
      power_b_q   <= {SFIFO_WIDTH{1'b0}};
      power_c_q   <= {SFIFO_WIDTH{1'b0}};
      power_d_q   <= {SFIFO_WIDTH{1'b0}};
      word_out_q  <= {SFIFO_WIDTH{1'b0}};
      pad_err_q   <= 1'b0;
      seen_q      <= 1'b0;
      for (int i = 0; i < PKT_WORDS; i++) begin
        raw_q[i] <= {SFIFO_WIDTH{1'b0}};
      end
    end else begin
      pkt_valid_q <= commit_s;
      word_out_q  <= raw_q[word_sel];
      if (commit_s) begin
        evt_cnt_q <= pkt_s[W_EVT][DATA_WIDTH-1:0];
        status_q  <= pkt_s[W_EVT][SFIFO_WIDTH-1 -: DATA_WIDTH];
        x_pos_q   <= pkt_s[W_XY][SFIFO_WIDTH-1 -: DATA_WIDTH];
        y_pos_q   <= pkt_s[W_XY][DATA_WIDTH-1:0];
        s_sum_q   <= pkt_s[W_S][SFIFO_WIDTH-1 -: DATA_WIDTH];
        power_a_q <= pkt_s[W_PA];
        power_b_q <= pkt_s[W_PB];
        power_c_q <= pkt_s[W_PC];
        power_d_q <= pkt_s[W_PD];
        pad_err_q <= pad_err_q | pad_s;
        seen_q    <= 1'b1;
        for (int i = 0; i < PKT_WORDS; i++) begin
          raw_q[i] <= pkt_s[i];
        end
      end
    end
  end

  sat_cnt16 u_sync_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (sync_inc_s),
    .cnt_o (sync_err_cnt)
  );

  sat_cnt16 u_gap_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (gap_s),
    .cnt_o (evt_gap_cnt)
  );

  // Reads are held off while reset is applied so no words are consumed blindly
  assign fifo_rd   = rd_s & ~rst;
  assign pkt_valid = pkt_valid_q;
  assign evt_cnt   = evt_cnt_q;
  assign status    = status_q;
  assign x_pos     = x_pos_q;
  assign y_pos     = y_pos_q;
  assign s_sum     = s_sum_q;
  assign power_a   = power_a_q;
  assign power_b   = power_b_q;
  assign power_c   = power_c_q;
  assign power_d   = power_d_q;
  assign word_out  = word_out_q;
  assign pad_err   = pad_err_q;

endmodule

// File: tb/tb_slow_pkt_reader.sv
// Directed bench for slow_pkt_reader with a FIFO model (read latency 1,
// count lag 2) and a scoreboard of expected packets.
module tb_slow_pkt_reader;

  typedef logic [15:0][31:0] pkt_t;
  typedef struct packed {
    pkt_t        w;
    logic [15:0] gap;
    logic [15:0] sync;
    logic        pad;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] fifo_dout = 32'd0;
  logic [5:0]  fifo_rd_count;
  logic        fifo_rd;
  logic        pkt_valid;
  logic [15:0] evt_cnt, status, x_pos, y_pos, s_sum;
  logic [31:0] power_a, power_b, power_c, power_d;
  logic [3:0]  word_sel;
  logic [31:0] word_out;
  logic [15:0] sync_err_cnt, evt_gap_cnt;
  logic        pad_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_total = 0;
  int pv_total = 0;

  logic [31:0] fifo_q [$];
  exp_t        sb_q [$];
  logic [5:0]  c1 = 6'd0;
  logic [5:0]  c2 = 6'd0;

  logic [15:0] gap_m = 16'd0;
  logic [15:0] sync_m = 16'd0;
  logic        pad_m = 1'b0;
  logic        seen_m = 1'b0;
  logic [15:0] prev_m = 16'd0;

  always #5 clk = ~clk;

  slow_pkt_reader dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_dout(fifo_dout),
    .fifo_rd_count(fifo_rd_count), .fifo_rd(fifo_rd), .pkt_valid(pkt_valid),
    .evt_cnt(evt_cnt), .status(status), .x_pos(x_pos), .y_pos(y_pos),
    .s_sum(s_sum), .power_a(power_a), .power_b(power_b), .power_c(power_c),
    .power_d(power_d), .word_sel(word_sel), .word_out(word_out),
    .sync_err_cnt(sync_err_cnt), .evt_gap_cnt(evt_gap_cnt), .pad_err(pad_err)
  );

  assign fifo_rd_count = c2;

  // FIFO model: data one cycle after the read, count two cycles stale
  always @(posedge clk) begin
    int sz;
    sz = fifo_q.size();
    cyc <= cyc + 1;
    c1 <= (sz > 63) ? 6'd63 : 6'(sz);
    c2 <= c1;
    if (fifo_rd && (sz != 0)) fifo_dout <= fifo_q.pop_front();
  end

  // Read/valid activity counters and read-on-empty protocol check
  always @(negedge clk) begin
    if (fifo_rd) begin
      rd_total++;
      checks++;
      assert (fifo_rd_count !== 6'd0) else begin
        errors++;
        $error("FAIL rd_on_empty observed count=%0d expected nonzero", fifo_rd_count);
      end
    end
    if (pkt_valid === 1'b1) pv_total++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t mk_pkt(input logic [15:0] evt, input logic [31:0] xy,
                                  input logic [31:0] w3, input logic [31:0] pbase,
                                  input logic [31:0] w11);
    pkt_t p;
    p[0] = 32'h4142504D;
    p[1] = {16'h0003, evt};
    p[2] = xy;
    p[3] = w3;
    for (int i = 0; i < 4; i++) p[4+i] = pbase + 32'(i);
    for (int i = 8; i < 16; i++) p[i] = 32'hC0DE0000 + 32'(i);
    p[11] = w11;
    return p;
  endfunction

  // Queue the packet in the FIFO and its expected decode in the scoreboard
  task automatic push_pkt(input pkt_t p);
    exp_t e;
    for (int i = 0; i < 16; i++) fifo_q.push_back(p[i]);
    if (seen_m && (p[1][15:0] != 16'(prev_m + 16'd1))) gap_m = gap_m + 16'd1;
    seen_m = 1'b1;
    prev_m = p[1][15:0];
    if ((p[3][15:0] != 16'd0) || (p[11] != 32'd0)) pad_m = 1'b1;
    e.w = p; e.gap = gap_m; e.sync = sync_m; e.pad = pad_m;
    sb_q.push_back(e);
  endtask

  task automatic check_pkt();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL sb_empty observed=pkt_valid expected=no packet");
      return;
    end
    e = sb_q.pop_front();
    chk("evt_cnt", 32'(evt_cnt), 32'(e.w[1][15:0]));
    chk("status",  32'(status),  32'(e.w[1][31:16]));
    chk("x_pos",   32'(x_pos),   32'(e.w[2][31:16]));
    chk("y_pos",   32'(y_pos),   32'(e.w[2][15:0]));
    chk("s_sum",   32'(s_sum),   32'(e.w[3][31:16]));
    chk("power_a", power_a, e.w[4]);
    chk("power_b", power_b, e.w[5]);
    chk("power_c", power_c, e.w[6]);
    chk("power_d", power_d, e.w[7]);
    chk("evt_gap_cnt",  32'(evt_gap_cnt),  32'(e.gap));
    chk("sync_err_cnt", 32'(sync_err_cnt), 32'(e.sync));
    chk("pad_err",      32'(pad_err),      32'(e.pad));
  endtask

  // Advance at least one cycle, then wait (bounded) for pkt_valid
  task automatic wait_valid(output int t);
    int n;
    n = 0;
    @(negedge clk);
    while ((pkt_valid !== 1'b1) && (n < 300)) begin @(negedge clk); n++; end
    chk("pkt_valid_seen", 32'(pkt_valid), 32'd1);
    t = cyc;
  endtask

  task automatic wait_rd(output int t);
    int n;
    n = 0;
    while ((fifo_rd !== 1'b1) && (n < 300)) begin @(negedge clk); n++; end
    chk("fifo_rd_seen", 32'(fifo_rd), 32'd1);
    t = cyc;
  endtask

  function automatic logic any_out();
    return |{pkt_valid, evt_cnt, status, x_pos, y_pos, s_sum, power_a, power_b,
             power_c, power_d, word_out, sync_err_cnt, evt_gap_cnt, pad_err, fifo_rd};
  endfunction

  initial begin
    int   t0, tv, t1, base_rd, base_pv, n;
    pkt_t p;

    rst = 1'b1; enable = 1'b1; word_sel = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(any_out()), 32'd0);
    rst = 1'b0;

    // Nominal packet and its timing
    @(negedge clk);
    push_pkt(mk_pkt(16'h0005, 32'h0010FFF0, 32'h12340000, 32'd1, 32'd0));
    wait_rd(t0);
    wait_valid(tv);
    chk("valid_latency", 32'(tv - t0), 32'd18);
    check_pkt();
    chk("word_out_before", word_out, 32'd0);
    // Hunt and resync: three junk words, then evt 6
    fifo_q.push_back(32'hDEAD0001);
    fifo_q.push_back(32'hDEAD0002);
    fifo_q.push_back(32'h4142504C);
    sync_m = 16'd1;
    push_pkt(mk_pkt(16'h0006, 32'h00200030, 32'h00400000, 32'd100, 32'd0));
    @(negedge clk);
    chk("valid_pulse_width", 32'(pkt_valid), 32'd0);
    chk("word_out_after", word_out, 32'h4142504D);
    wait_rd(t1);
    chk("guard_next_rd", 32'(t1 - tv), 32'd3);
    wait_valid(tv);
    check_pkt();

    // Continuity: 7 (ok), 9 (gap), 0xFFFF (gap), 0x0000 (wrap, ok)
    push_pkt(mk_pkt(16'h0007, 32'h11112222, 32'h00010000, 32'd200, 32'd0));
    push_pkt(mk_pkt(16'h0009, 32'h33334444, 32'h00020000, 32'd300, 32'd0));
    for (int k = 0; k < 2; k++) begin wait_valid(tv); check_pkt(); end
    push_pkt(mk_pkt(16'hFFFF, 32'h55556666, 32'h00030000, 32'd400, 32'd0));
    push_pkt(mk_pkt(16'h0000, 32'h77778888, 32'h00040000, 32'd500, 32'd0));
    for (int k = 0; k < 2; k++) begin wait_valid(tv); check_pkt(); end

    // Pad error, sticky flag and raw word access
    word_sel = 4'd11;
    push_pkt(mk_pkt(16'h0001, 32'h9999AAAA, 32'h00050000, 32'd600, 32'h00000001));
    wait_valid(tv);
    check_pkt();
    chk("word_out_old_w11", word_out, 32'd0);
    @(negedge clk);
    chk("word_out_new_w11", word_out, 32'h00000001);
    push_pkt(mk_pkt(16'h0002, 32'hBBBBCCCC, 32'h00060000, 32'd700, 32'd0));
    wait_valid(tv);
    check_pkt();

    // Stall: only 10 words available
    repeat (4) @(negedge clk);
    base_rd = rd_total;
    base_pv = pv_total;
    p = mk_pkt(16'h0042, 32'h01020304, 32'h00070000, 32'd800, 32'd0);
    for (int i = 0; i < 10; i++) fifo_q.push_back(p[i]);
    repeat (40) @(negedge clk);
    chk("stall_no_rd", 32'(rd_total - base_rd), 32'd0);
    chk("stall_no_valid", 32'(pv_total - base_pv), 32'd0);

    // Rest of the packet arrives; reset while the body burst is running
    for (int i = 10; i < 16; i++) fifo_q.push_back(p[i]);
    n = 0;
    while ((rd_total < base_rd + 7) && (n < 200)) begin @(negedge clk); n++; end
    chk("body_reads_seen", 32'(rd_total >= base_rd + 7), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_pkt_reset", 32'(any_out()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_hold", 32'(any_out()), 32'd0);
    chk("no_valid_partial", 32'(pv_total - base_pv), 32'd0);

    // Fresh packet after reset: leftover words are hunted away
    gap_m = 16'd0; seen_m = 1'b0; pad_m = 1'b0; sync_m = 16'd1;
    push_pkt(mk_pkt(16'h0100, 32'h0A0B0C0D, 32'h00080000, 32'd900, 32'd0));
    wait_valid(tv);
    check_pkt();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slow_pkt_reader.md
# slow_pkt_reader

Reads the 16-word ABPM event packets out of the slow FIFO on the MB bus clock side, checks framing and event continuity, and latches the fields into registers for the MB register map. It is the consumer end of the slow-FIFO packet stream: one packet per BPM event, PID `0x4142504D`. It resynchronises to the next PID after any framing loss.

## Interface
- `SFIFO_WIDTH`, default 32: FIFO word width.
- `DATA_WIDTH`, default 16: narrow field width.
- `PKT_WORDS`, default 16: words per packet.
- `CNT_WIDTH`, default 6: width of the FIFO read-count input.
- `PID`, default 32'h4142504D: packet header word.
- `clk` in 1: MB bus clock; the FIFO read side runs on this clock.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: permits starting a new packet.
- `fifo_dout` in 32: FIFO read data, valid the cycle after `fifo_rd`.
- `fifo_rd_count` in 6: FIFO read data count; lags reads by up to 2 cycles.
- `fifo_rd` out 1: FIFO read enable.
- `pkt_valid` out 1: one-cycle pulse when new packet fields are latched.
- `evt_cnt` out 16: word1[15:0].
- `status` out 16: word1[31:16].
- `x_pos` out 16: word2[31:16].
- `y_pos` out 16: word2[15:0].
- `s_sum` out 16: word3[31:16].
- `power_a` out 32: word4.
- `power_b` out 32: word5.
- `power_c` out 32: word6.
- `power_d` out 32: word7.
- `word_sel` in 4: raw-word index into the latched packet.
- `word_out` out 32: latched word[`word_sel`], registered.
- `sync_err_cnt` out 16: number of hunt episodes (saturating).
- `evt_gap_cnt` out 16: number of event-number discontinuities (saturating).
- `pad_err` out 1: sticky; set when word3[15:0] or word11 is non-zero.

## Operation
- **IDLE**
  - Requires `enable=1`, `fifo_rd_count>=PKT_WORDS` and guard counter = 0.
  - When all hold: assert `fifo_rd` for 1 cycle and go to HUNT.
- **HUNT**
  - Compares the returned word with `PID`.
  - Match: go to BODY; the word is stored as buf[0].
  - Mismatch: discard the word. On the first mismatch of an episode, increment `sync_err_cnt`. Then issue the next single read when `fifo_rd_count!=0` and no read is outstanding, i.e. at most 1 word per 2 cycles.
- **BODY**
  - Waits until `fifo_rd_count>=PKT_WORDS`. This is conservative and absorbs count lag.
  - Then issues 15 back-to-back reads and captures returned words into buf[1..15] in order.
  - `enable` is not sampled here.
- **COMMIT** (1 cycle)
  - Updates all field outputs and the raw buffer copy, and pulses `pkt_valid`.
  - Event continuity:
    - If a packet has been seen since reset and word1[15:0] != previous `evt_cnt`+1 mod 2^16, increment `evt_gap_cnt`.
    - The first packet after reset never counts as a gap.
  - Loads guard=2, then goes to IDLE.
- **Counters and flags**: `sync_err_cnt` and `evt_gap_cnt` saturate at 0xFFFF. `pad_err` clears only on `rst`.
- **Packet layout**:
  - word0: PID.
  - word1: {status, evt}.
  - word2: {X, Y}.
  - word3: {S, 0}.
  - words 4-7: powers A-D.
  - word8: {maxA, maxB}.
  - word9: {maxC, maxD}.
  - word10: {Xcal, Ycal}.
  - word11: 0.
  - words 12-13: cal power A/B.
  - words 14-15: drift gain A/B.
- **Raw access**: `word_out` is the latched word[`word_sel`]. It always reflects the last committed packet, never a partial one.

## Timing
- **Reset values**: all outputs 0, state IDLE, guard 0, "first packet" flag cleared. Any outstanding read data is ignored.
- **Reset mid-packet**: the partial packet is abandoned, and the outputs keep the reset value 0 until the next COMMIT. Remaining FIFO words are flushed by HUNT.
- **Nominal packet**:
  - T0: IDLE read of word0.
  - T1: PID compare.
  - T2..T16: `fifo_rd` high.
  - T3..T17: data words 1..15 returned.
  - T18: `pkt_valid=1`, fields visible.
  - Earliest next `fifo_rd` is T21, after COMMIT plus 2 guard cycles.
- **`fifo_rd` rules**: `fifo_rd` is never asserted while `fifo_rd_count==0`. `fifo_rd` never exceeds 1 word per cycle.
- **`enable`**: dropping `enable` mid-packet completes the packet; no new packet starts while `enable=0`.
- **Simultaneous events**: a COMMIT with a gap and a pad error updates both in the same cycle.
- **Raw access latency**: `word_out` follows `word_sel` with 1-cycle latency. It updates on the cycle after COMMIT.

## Structure
- Shared package `abpm_pkt_pkg` holds:
  - `PID` and `PKT_WORDS`;
  - word-index constants (`W_PID`, `W_EVT`, `W_XY`, `W_S`, `W_PA`..`W_PD`, `W_MAXAB`, `W_MAXCD`, `W_XYCAL`, `W_PAD`, `W_CALPA`, `W_CALPB`, `W_DRA`, `W_DRB`);
  - the state enum.
- The writer-side packer uses the same constants.
- One sub-module, `sat_cnt16` (saturating increment counter), instantiated twice.
- FIFO model in the bench: read latency 1, count lag 2.

## Test plan
- **Nominal packet**: load 16 words (PID, 0x00030005, 0x0010FFF0, 0x12340000, powers 1..4, ...) -> `pkt_valid` at T18; `evt_cnt=5`, `status=3`, `x_pos=0x0010`, `y_pos=0xFFF0`, `s_sum=0x1234`, `power_c=3`; no errors.
- **Hunt and resync**: 3 junk words, then a valid packet with evt 6 -> `sync_err_cnt=1`, one `pkt_valid`, `evt_cnt=6`, `evt_gap_cnt=0` (continuity from evt 5).
- **Event gap**: packets with evt 7 then evt 9 -> `evt_gap_cnt` +1. Wrap case 0xFFFF -> 0x0000 adds no gap.
- **Pad error and raw access**: word11=0x1 -> `pad_err=1` sticky after COMMIT; `word_sel=11` gives `word_out=0x00000001` one cycle later.
- **Stall and reset**: only 10 words present -> no `fifo_rd` beyond the protocol and no `pkt_valid`. `rst` during BODY -> all outputs 0, and the next full packet decodes correctly.
